keypad_multitap_scanner: RTL and testbench
==========================================

// Module: keypad_multitap_scanner
// PURPOSE
//  Drives the column strobes of a 4x4 matrix keypad and samples its row lines.
//  Debounces presses and decodes phone-style multi-tap letter entry.
//  Emits one ASCII letter per SUBMIT key press.
//  One instance sits on each of the host and player keypads, feeding the game FSM.
// PARAMETERS
//  SCAN_DIV     100     clk cycles each column stays strobed before advancing
//  DEB_SCANS    4       consecutive full scans a key (or release) must persist
//  TAP_TIMEOUT  500000  clk cycles after release in which a repeat tap cycles the letter
// PORTS
//  clk           in   1  system clock, rising edge
//  nRst          in   1  asynchronous active-low reset
//  row           in   4  keypad rows, active-high; row[3]=R0 .. row[0]=R3
//  col           out  4  one-hot column strobe; col[0]=C0 .. col[3]=C3
//  pending_char  out  8  ASCII of the letter currently being tapped; 8'h00 if none
//  pending_valid out  1  pending_char holds a letter
//  letter        out  8  ASCII of the last submitted letter, held until the next submit
//  letter_strobe out  1  one-cycle pulse when letter updates
//  submit_err    out  1  one-cycle pulse on SUBMIT with nothing pending
// BEHAVIOUR
//  Reset values: col=4'b0001, pending_char=0, pending_valid=0, letter=0, letter_strobe=0,
//    submit_err=0, all counters 0, FSM=IDLE. Reset mid-press discards the pending letter.
//  Scan:
//   - col rotates left every SCAN_DIV cycles (0001->0010->0100->1000->0001).
//   - One full scan = 4*SCAN_DIV cycles.
//   - Each column's row[] is registered on the last cycle of its slot.
//   - Key id = {row_idx[1:0], col_idx[1:0]}. If several rows are high, the lowest row_idx wins.
//   - Only the first key found in a scan counts.
//  Debounce:
//   - A candidate key must read identically for DEB_SCANS consecutive scans to register as pressed.
//   - "No key" must read for DEB_SCANS consecutive scans to register as released.
//   - A different key read in any scan restarts the count.
//  Key map (row,col): (0,1)=ABC (0,2)=DEF (0,3)=GHI (1,0)=JKL (1,1)=MNO (1,2)=PQRS
//    (1,3)=TUV (2,0)=WXYZ (3,0)=SUBMIT (3,2)=CLEAR; all other keys are ignored.
//  FSM states IDLE, DOWN, TAPWIN; tap index idx is 2 bits:
//   - IDLE + letter key press:
//       - pending = first letter of the key, idx=0, pending_valid=1.
//       - Go to DOWN. The key id is remembered.
//   - DOWN + release: go to TAPWIN and clear the timeout counter.
//   - TAPWIN + same key press before TAP_TIMEOUT:
//       - idx=(idx+1) mod the key's letter count (3 or 4), e.g. S->P.
//       - pending updates. Go to DOWN.
//   - TAPWIN + different letter key: pending is replaced by that key's first letter, idx=0. Go to DOWN.
//   - TAPWIN timeout: go to IDLE with pending kept. A later press of the same key restarts at idx=0.
//   - SUBMIT press, any state:
//       - If pending_valid: letter<=pending_char, letter_strobe=1, pending cleared. Go to IDLE.
//       - Otherwise submit_err=1.
//   - CLEAR press, any state: pending cleared. Go to IDLE. No strobe.
//  Latency: letter_strobe fires exactly 1 clk after SUBMIT's debounced press is registered.
//  Holding a key never auto-repeats; only press edges act. Presses and releases during debounce are filtered.
// TESTING
//  1. Reset, no keys -> col cycles 0001,0010,0100,1000 at SCAN_DIV; all outputs 0.
//  2. Tap (0,1) once, release, tap SUBMIT -> pending_char 8'h41 'A'; letter=8'h41 with a 1-cycle strobe.
//  3. Tap (1,2) 4x within the window -> P,Q,R,S; a 5th tap -> 'P'. SUBMIT -> letter 8'h50.
//  4. Tap (1,0), wait >TAP_TIMEOUT, tap (1,0) again -> pending stays 'J' (8'h4A), not 'K'.
//  5. SUBMIT with nothing pending -> submit_err pulses and letter is unchanged.
//     Then a 1-scan glitch on row -> no press is registered.
//  6. Assert nRst mid-press with pending 'M' -> all outputs return to reset values immediately.
//     After release, the key must be re-pressed to register.

Source files
------------

// File: rtl/keypad_multitap_scanner_if.sv
// Keypad scanner signal bundle: row/column matrix lines plus decoded letter outputs.
// master = the scanner itself, slave = keypad hardware plus the consuming game FSM.
interface keypad_multitap_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] pending_char;
    logic       pending_valid;
    logic [7:0] letter;
    logic       letter_strobe;
    logic       submit_err;

    modport master (
        input  row,
        output col,
        output pending_char,
        output pending_valid,
        output letter,
        output letter_strobe,
        output submit_err
    );

    modport slave (
        output row,
        input  col,
        input  pending_char,
        input  pending_valid,
        input  letter,
        input  letter_strobe,
        input  submit_err
    );
endinterface

// File: rtl/keypad_multitap_scanner.sv
// 4x4 keypad column scanner with per-scan debounce and phone-style multi-tap decode.
// state  | meaning
// IDLE   | no key held; any pending letter stays but a new tap starts a fresh cycle
// DOWN   | a letter key is held, its letter is pending
// TAPWIN | letter key released; a repeat tap of it before the timeout advances the letter
module keypad_multitap_scanner #(
    parameter int SCAN_DIV    = 100,
    parameter int DEB_SCANS   = 4,
    parameter int TAP_TIMEOUT = 500000
) (
    input  logic                        clk,
    input  logic                        nRst,
    keypad_multitap_scanner_if.master   kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_SCANS + 1);
    localparam int TMO_W = $clog2(TAP_TIMEOUT + 1);

    localparam logic [3:0] KEY_SUBMIT = 4'd12;
    localparam logic [3:0] KEY_CLEAR  = 4'd14;

    typedef enum logic [1:0] {IDLE, DOWN, TAPWIN} state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic             found_q, found_d;
    logic [3:0]       skey_q, skey_d;

    logic             cand_valid_q, cand_valid_d;
    logic [3:0]       cand_key_q, cand_key_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             stable_valid_q, stable_valid_d;
    logic [3:0]       stable_key_q, stable_key_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [3:0]       press_key_q, press_key_d;

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic             pv_q, pv_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       key_q, key_d;
    logic [7:0]       letter_q, letter_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             slot_end, first_col, row_hit, scan_done;
    logic [1:0]       row_sel;
    logic             same, reached, differs;
    logic [7:0]       key_base;
    logic             key_four, key_is_letter;

    // Column scan and per-scan capture of the first key seen
    always_comb begin
        slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
        first_col = (col_idx_q == 2'd0);
        div_d     = slot_end ? '0 : div_q + 1'b1;
        col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;
        row_hit   = |kp.row;
        if (kp.row[3])      row_sel = 2'd0;
        else if (kp.row[2]) row_sel = 2'd1;
        else if (kp.row[1]) row_sel = 2'd2;
        else                row_sel = 2'd3;
        found_d = found_q;
        skey_d  = skey_q;
        if (slot_end) begin
            found_d = first_col ? row_hit : (found_q | row_hit);
            if (row_hit && (first_col || !found_q))
                skey_d = {row_sel, col_idx_q};
        end
        scan_done = slot_end && (col_idx_q == 2'd3);
    end

    // Debounce: a scan result must repeat DEB_SCANS times before it becomes stable
    always_comb begin
        cand_valid_d   = cand_valid_q;
        cand_key_d     = cand_key_q;
        cnt_d          = cnt_q;
        stable_valid_d = stable_valid_q;
        stable_key_d   = stable_key_q;
        armed_d        = armed_q;
        press_d        = 1'b0;
        release_d      = 1'b0;
        press_key_d    = press_key_q;
        same           = (found_d == cand_valid_q) && (!found_d || (skey_d == cand_key_q));
        reached        = 1'b0;
        differs        = (found_d != stable_valid_q) || (found_d && (skey_d != stable_key_q));
        if (scan_done) begin
            if (!same) begin
                cand_valid_d = found_d;
                cand_key_d   = skey_d;
                cnt_d        = DEB_W'(1);
            end else if (cnt_q != DEB_W'(DEB_SCANS)) begin
                cnt_d = cnt_q + 1'b1;
            end
            reached = (cnt_d == DEB_W'(DEB_SCANS)) && ((cnt_d != cnt_q) || !same);
            if (reached) begin
                stable_valid_d = found_d;
                stable_key_d   = skey_d;
                // Keys already held at reset are swallowed until a clean release is seen
                if (!found_d) begin
                    armed_d   = 1'b1;
                    release_d = armed_q && stable_valid_q;
                end else if (armed_q && differs) begin
                    press_d     = 1'b1;
                    press_key_d = skey_d;
                end
            end
        end
    end

    always_comb begin
        key_base      = 8'h00;
        key_four      = 1'b0;
        key_is_letter = 1'b1;
        case (press_key_q)
            4'd1:    key_base = 8'h41;
            4'd2:    key_base = 8'h44;
            4'd3:    key_base = 8'h47;
            4'd4:    key_base = 8'h4A;
            4'd5:    key_base = 8'h4D;
            4'd6:    begin key_base = 8'h50; key_four = 1'b1; end
            4'd7:    key_base = 8'h54;
            4'd8:    begin key_base = 8'h57; key_four = 1'b1; end
            default: key_is_letter = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pv_d     = pv_q;
        idx_d    = idx_q;
        key_d    = key_q;
        letter_d = letter_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        tmo_d    = tmo_q;
        if (state_q == TAPWIN && tmo_q != TMO_W'(TAP_TIMEOUT - 1))
            tmo_d = tmo_q + 1'b1;
        if (press_q) begin
            if (press_key_q == KEY_SUBMIT) begin
                if (pv_q) begin
                    letter_d = pc_q;
                    strobe_d = 1'b1;
                    pc_d     = 8'h00;
                    pv_d     = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end else if (press_key_q == KEY_CLEAR) begin
                pc_d    = 8'h00;
                pv_d    = 1'b0;
                state_d = IDLE;
            end else if (key_is_letter) begin
                if (state_q == TAPWIN && press_key_q == key_q)
                    idx_d = (idx_q == (key_four ? 2'd3 : 2'd2)) ? 2'd0 : idx_q + 2'd1;
                else
                    idx_d = 2'd0;
                key_d   = press_key_q;
                pc_d    = key_base + 8'(idx_d);
                pv_d    = 1'b1;
                state_d = DOWN;
            end
        end else if (release_q && state_q == DOWN) begin
            state_d = TAPWIN;
            tmo_d   = '0;
        end else if (state_q == TAPWIN && tmo_q == TMO_W'(TAP_TIMEOUT - 1)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            div_q          <= '0;
            col_idx_q      <= 2'd0;
            found_q        <= 1'b0;
            skey_q         <= 4'd0;
            cand_valid_q   <= 1'b0;
            cand_key_q     <= 4'd0;
            cnt_q          <= '0;
            stable_valid_q <= 1'b0;
            stable_key_q   <= 4'd0;
            armed_q        <= 1'b0;
            press_q        <= 1'b0;
            release_q      <= 1'b0;
            press_key_q    <= 4'd0;
            state_q        <= IDLE;
            pc_q           <= 8'h00;
            pv_q           <= 1'b0;
            idx_q          <= 2'd0;
            key_q          <= 4'd0;
            letter_q       <= 8'h00;
            strobe_q       <= 1'b0;
            err_q          <= 1'b0;
            tmo_q          <= '0;
        end else begin
            div_q          <= div_d;
            col_idx_q      <= col_idx_d;
            found_q        <= found_d;
            skey_q         <= skey_d;
            cand_valid_q   <= cand_valid_d;
            cand_key_q     <= cand_key_d;
            cnt_q          <= cnt_d;
            stable_valid_q <= stable_valid_d;
            stable_key_q   <= stable_key_d;
            armed_q        <= armed_d;
            press_q        <= press_d;
            release_q      <= release_d;
            press_key_q    <= press_key_d;
            state_q        <= state_d;
            pc_q           <= pc_d;
            pv_q           <= pv_d;
            idx_q          <= idx_d;
            key_q          <= key_d;
            letter_q       <= letter_d;
            strobe_q       <= strobe_d;
            err_q          <= err_d;
            tmo_q          <= tmo_d;
        end
    end

    assign kp.col           = 4'(4'b0001 << col_idx_q);
    assign kp.pending_char  = pc_q;
    assign kp.pending_valid = pv_q;
    assign kp.letter        = letter_q;
    assign kp.letter_strobe = strobe_q;
    assign kp.submit_err    = err_q;
endmodule

// File: tb/tb_keypad_multitap_scanner.sv
// Directed bench for the keypad scanner: a tap table plus reset, rotation and glitch sequences.
module tb_keypad_multitap_scanner;
    localparam int SCAN_DIV = 4;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int TMO      = 300;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        int         gap;
        logic [7:0] pc;
        logic       pv;
        logic [7:0] letter;
        int         strobes;
        int         errs;
    } vec_t;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic held = 1'b0;
    logic [1:0] hr = 2'd0;
    logic [1:0] hc = 2'd0;
    logic [3:0] row_m;
    int strobe_cyc = 0;
    int err_cyc = 0;
    int total = 0;
    int passed = 0;
    vec_t vecs[21];

    keypad_multitap_scanner_if kp_if ();

    keypad_multitap_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEB_SCANS   (4),
        .TAP_TIMEOUT (TMO)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .kp   (kp_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_m = 4'b0000;
        if (held && kp_if.col[hc]) row_m[3 - hr] = 1'b1;
    end
    assign kp_if.row = row_m;

    always @(negedge clk) begin
        if (kp_if.letter_strobe) strobe_cyc++;
        if (kp_if.submit_err)    err_cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] c, input int gap,
                                input logic [7:0] pc, input logic pv, input logic [7:0] letter,
                                input int strobes, input int errs);
        vec_t v;
        v.r = r; v.c = c; v.gap = gap; v.pc = pc; v.pv = pv;
        v.letter = letter; v.strobes = strobes; v.errs = errs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tap(input logic [1:0] r, input logic [1:0] c, input int gap);
        @(posedge clk);
        hr = r; hc = c; held = 1'b1;
        repeat (6 * SCAN) @(posedge clk);
        held = 1'b0;
        repeat (6 * SCAN + gap) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag, input logic [7:0] pc, input logic pv,
                               input logic [7:0] letter, input int strobes, input int errs);
        chk({tag, ".pending_char"}, 32'(kp_if.pending_char), 32'(pc));
        chk({tag, ".pending_valid"}, 32'(kp_if.pending_valid), 32'(pv));
        chk({tag, ".letter"}, 32'(kp_if.letter), 32'(letter));
        chk({tag, ".strobe_cycles"}, 32'(strobe_cyc), 32'(strobes));
        chk({tag, ".err_cycles"}, 32'(err_cyc), 32'(errs));
    endtask

    initial begin
        vecs[0]  = mk(2'd0, 2'd1, 0,   8'h41, 1'b1, 8'h00, 0, 0);
        vecs[1]  = mk(2'd3, 2'd0, 0,   8'h00, 1'b0, 8'h41, 1, 0);
        vecs[2]  = mk(2'd1, 2'd2, 0,   8'h50, 1'b1, 8'h41, 1, 0);
        vecs[3]  = mk(2'd1, 2'd2, 0,   8'h51, 1'b1, 8'h41, 1, 0);
        vecs[4]  = mk(2'd1, 2'd2, 0,   8'h52, 1'b1, 8'h41, 1, 0);
        vecs[5]  = mk(2'd1, 2'd2, 0,   8'h53, 1'b1, 8'h41, 1, 0);
        vecs[6]  = mk(2'd1, 2'd2, 0,   8'h50, 1'b1, 8'h41, 1, 0);
        vecs[7]  = mk(2'd3, 2'd0, 0,   8'h00, 1'b0, 8'h50, 2, 0);
        vecs[8]  = mk(2'd1, 2'd0, 400, 8'h4A, 1'b1, 8'h50, 2, 0);
        vecs[9]  = mk(2'd1, 2'd0, 0,   8'h4A, 1'b1, 8'h50, 2, 0);
        vecs[10] = mk(2'd1, 2'd0, 0,   8'h4B, 1'b1, 8'h50, 2, 0);
        vecs[11] = mk(2'd3, 2'd2, 0,   8'h00, 1'b0, 8'h50, 2, 0);
        vecs[12] = mk(2'd3, 2'd0, 0,   8'h00, 1'b0, 8'h50, 2, 1);
        vecs[13] = mk(2'd0, 2'd3, 0,   8'h47, 1'b1, 8'h50, 2, 1);
        vecs[14] = mk(2'd2, 2'd0, 0,   8'h57, 1'b1, 8'h50, 2, 1);
        vecs[15] = mk(2'd2, 2'd0, 0,   8'h58, 1'b1, 8'h50, 2, 1);
        vecs[16] = mk(2'd2, 2'd0, 0,   8'h59, 1'b1, 8'h50, 2, 1);
        vecs[17] = mk(2'd2, 2'd0, 0,   8'h5A, 1'b1, 8'h50, 2, 1);
        vecs[18] = mk(2'd2, 2'd0, 0,   8'h57, 1'b1, 8'h50, 2, 1);
        vecs[19] = mk(2'd0, 2'd0, 0,   8'h57, 1'b1, 8'h50, 2, 1);
        vecs[20] = mk(2'd3, 2'd0, 0,   8'h00, 1'b0, 8'h57, 3, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.col", 32'(kp_if.col), 32'h1);
        chk_outputs("reset", 8'h00, 1'b0, 8'h00, 0, 0);
        nRst = 1'b1;

        // After n rising edges out of reset the column index is n/SCAN_DIV mod 4
        for (int n = 1; n <= SCAN; n++) begin
            @(posedge clk); #1;
            chk($sformatf("col_rot[%0d]", n), 32'(kp_if.col), 32'(4'b0001 << ((n / SCAN_DIV) % 4)));
        end

        repeat (6 * SCAN) @(posedge clk);
        for (int i = 0; i < 21; i++) begin
            tap(vecs[i].r, vecs[i].c, vecs[i].gap);
            chk_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pv, vecs[i].letter,
                        vecs[i].strobes, vecs[i].errs);
        end

        // A key seen for a single scan must not register
        @(posedge clk);
        hr = 2'd0; hc = 2'd1; held = 1'b1;
        repeat (SCAN) @(posedge clk);
        held = 1'b0;
        repeat (8 * SCAN) @(posedge clk);
        @(negedge clk);
        chk("glitch.pending_valid", 32'(kp_if.pending_valid), 32'h0);
        chk("glitch.pending_char", 32'(kp_if.pending_char), 32'h0);

        // Reset while M is held and pending
        @(posedge clk);
        hr = 2'd1; hc = 2'd1; held = 1'b1;
        repeat (6 * SCAN) @(posedge clk);
        @(negedge clk);
        chk("mid.pending_char", 32'(kp_if.pending_char), 32'h4D);
        nRst = 1'b0;
        #1;
        chk("mid_rst.col", 32'(kp_if.col), 32'h1);
        chk("mid_rst.pending_char", 32'(kp_if.pending_char), 32'h0);
        chk("mid_rst.pending_valid", 32'(kp_if.pending_valid), 32'h0);
        chk("mid_rst.letter", 32'(kp_if.letter), 32'h0);
        chk("mid_rst.strobe", 32'(kp_if.letter_strobe), 32'h0);
        chk("mid_rst.err", 32'(kp_if.submit_err), 32'h0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (8 * SCAN) @(posedge clk);
        @(negedge clk);
        chk("held_after_rst.pending_valid", 32'(kp_if.pending_valid), 32'h0);
        held = 1'b0;
        repeat (6 * SCAN) @(posedge clk);
        @(negedge clk);
        chk("released_after_rst.pending_valid", 32'(kp_if.pending_valid), 32'h0);
        tap(2'd1, 2'd1, 0);
        chk("repress.pending_char", 32'(kp_if.pending_char), 32'h4D);
        chk("repress.pending_valid", 32'(kp_if.pending_valid), 32'h1);
        chk("repress.letter", 32'(kp_if.letter), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
